sonic_ring_reader_128_2: RTL
============================

# sonic_ring_reader_128_2

Transmit-side counterpart of the 2-bit-in / 128-bit-out sync ring. It drains a 256-entry ring of 128-bit words, held in a synchronous RAM outside this block, and emits them as a continuous stream of 2-bit symbols, one symbol per accepted cycle. It sits between the host/DMA side, which fills the ring and advances `wr_ptr`, and the bit-level TX path, which consumes 2 bits per clock. It issues RAM reads itself and prefetches one word so the symbol stream has no bubbles across word boundaries.

## Interface
Parameters: none (widths fixed: 128-bit word, 2-bit symbol, 8-bit word pointer, 14-bit symbol address).

- `clock`  in  1  single clock; everything is synchronous to its rising edge
- `reset`  in  1  synchronous, active-high
- `wr_ptr`  in  8  producer write pointer, the next word slot the producer will fill
- `rd_address`  out  8  RAM read address, equal to the internal `rd_ptr`
- `rd_en`  out  1  RAM read strobe; `rd_data` is valid exactly 1 cycle later
- `rd_data`  in  128  RAM read data
- `rd_ptr`  out  8  consumer pointer returned to the producer for occupancy accounting
- `data_out`  out  2  current symbol; forced to 0 when `data_valid`=0
- `data_valid`  out  1  `data_out` holds a valid symbol
- `data_ready`  in  1  downstream accepts the symbol this cycle
- `sym_address`  out  14  ring address of the current symbol: {word pointer, symbol index 0..63}
- `empty`  out  1  high when `rd_ptr`==`wr_ptr` and neither holding register is valid

## Operation
**Symbol order**
- Symbol k (0..63) of a word is `word[2k+1:2k]`. Symbol 0 is emitted first.
- Bit 5 of the symbol index selects the upper or lower 64-bit half. This matches the write-side ring layout.

**State held**
- `cur` (128), `cur_valid`, `cur_ptr` (8), `sym_idx` (6)
- `nxt` (128), `nxt_valid`, `nxt_ptr` (8)
- `inflight` (1), plus the destination slot chosen for the in-flight word
- `rd_ptr` (8)

**Outputs**
- `data_out` = `cur[2*sym_idx +: 2]` when `cur_valid`, else 0.
- `data_valid` = `cur_valid`.
- `sym_address` = {`cur_ptr`, `sym_idx`}.

**Read issue**
- Combinational: `rd_en` = !`reset` & !`inflight` & !`nxt_valid` & (`rd_ptr` != `wr_ptr`).
- On `rd_en`: `rd_ptr` <= `rd_ptr`+1 (mod 256) and `inflight` <= 1. The issued pointer is tagged to the in-flight word.

**Landing (cycle after `rd_en`)**
- The word goes to `cur` if `cur` will be empty at this edge. That means `cur_valid`=0, or the last symbol (index 63) is being accepted while `nxt_valid`=0. In that case `sym_idx` <= 0.
- Otherwise the word goes to `nxt`.

**Advance**
- On `data_valid` & `data_ready`, `sym_idx` increments.
- At index 63 the word retires. `cur` <= `nxt` if `nxt_valid` (and `nxt_valid` <= 0); else the landing word if one arrives that cycle; else `cur_valid` <= 0.
- `sym_idx` wraps 63 -> 0 on retire.

**Boundaries**
- Backpressure: while `data_ready`=0, `data_out`, `sym_address` and `sym_idx` hold steady.
- Pointer wrap: 255 -> 0 is a natural 8-bit wrap. Ring usable depth is 255 words. Never overrunning `rd_ptr` is the producer's responsibility; it is not checked here.
- Empty ring: `rd_en` stays low and the stream drains to `data_valid`=0. There is no underflow error; the stream simply pauses.
- Occupancy: at most 2 words are held (`cur`+`nxt`), or 1 held plus 1 in flight. Never 3.
- `wr_ptr` moving backwards is undefined and not checked.

**Reset**
- Mid-operation reset clears all state at the next edge. A read in flight is discarded and its `rd_data` is ignored.
- Reset values: `rd_ptr`=0, `rd_address`=0, `rd_en`=0, `data_valid`=0, `data_out`=0, `sym_address`=0, `empty`=1, `inflight`=0.

## Timing
- First-word latency: `wr_ptr` changes from `rd_ptr` in cycle 0 -> `rd_en`=1 in cycle 0 -> `rd_data` sampled at end of cycle 1 -> `data_valid`=1 in cycle 2.
- Steady state with `data_ready` held high: the next word is prefetched into `nxt` during `cur`'s 64 symbols. The boundary is seamless: symbol 63 of word N is followed immediately by symbol 0 of word N+1.
- Refetch: after `nxt` moves into `cur`, `rd_en` reasserts in the following cycle.
- `rd_en` never asserts on two consecutive cycles.

## Test plan
- **Single word:** after reset, RAM[0]=128'h...E4 (low byte 8'hE4), `wr_ptr` 0->1 at cycle 0, `data_ready`=1 -> `data_valid` rises at cycle 2. Symbols 0..3 = 0,1,2,3 (from 8'hE4). `sym_address` runs 0..63. `data_valid` falls after 64 symbols. `empty`=1, `rd_ptr`=1.
- **Back-to-back:** 4 words, `wr_ptr`=4, `data_ready`=1 -> 256 consecutive valid symbols with no gap. `sym_address` runs 0..255. `rd_en` pulses are never adjacent.
- **Backpressure:** drop `data_ready` for 10 cycles mid-word at `sym_idx`=30 -> `data_out` and `sym_address` frozen, no symbol lost or duplicated. Also drop `data_ready` at `sym_idx`=63 -> no refetch beyond 2 held words.
- **Wrap:** preset pointers to 254 via reset plus 254 drained words, then `wr_ptr`=2 -> words 254, 255, 0, 1 are emitted in order. `sym_address` wraps 16383 -> 0.
- **Late producer:** `wr_ptr` advances one word every 100 cycles -> each word is emitted whole. `data_valid` is low between words. No stale data.
- **Mid-word reset:** assert `reset` for 1 cycle while `inflight`=1 and `sym_idx`=17 -> next cycle all outputs at reset values. The stale `rd_data` is ignored. Restart from `rd_ptr`=0.

Source files
------------

// File: rtl/sonic_ring_reader_128_2.sv
// Transmit-side ring reader: drains 128-bit words from an external synchronous RAM
// and streams them as 2-bit symbols, prefetching one word to avoid word-boundary bubbles.
module sonic_ring_reader_128_2 (
    input  logic         clock,
    input  logic         reset,
    input  logic [7:0]   wr_ptr,
    output logic [7:0]   rd_address,
    output logic         rd_en,
    input  logic [127:0] rd_data,
    output logic [7:0]   rd_ptr,
    output logic [1:0]   data_out,
    output logic         data_valid,
    input  logic         data_ready,
    output logic [13:0]  sym_address,
    output logic         empty
);

    localparam int unsigned WORD_W = 128;
    localparam int unsigned SYM_W  = 2;
    localparam int unsigned PTR_W  = 8;
    localparam int unsigned IDX_W  = 6;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(63);

    logic [WORD_W-1:0] cur;
    logic              cur_valid;
    logic [PTR_W-1:0]  cur_ptr;
    logic [IDX_W-1:0]  sym_idx;
    logic [WORD_W-1:0] nxt;
    logic              nxt_valid;
    logic [PTR_W-1:0]  nxt_ptr;
    logic              inflight;
    logic [PTR_W-1:0]  fl_ptr;
    logic [PTR_W-1:0]  rd_ptr_q;

    logic accept;
    logic retire;
    logic land_cur;

    // At landing nxt is always empty (a read is only issued with nxt free),
    // so the only choice is whether cur frees up at this same edge.
    always_comb begin
        accept   = cur_valid & data_ready;
        retire   = accept & (sym_idx == LAST_IDX);
        land_cur = inflight & (~cur_valid | (retire & ~nxt_valid));
        rd_en    = ~reset & ~inflight & ~nxt_valid & (rd_ptr_q != wr_ptr);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur       <= '0;
            cur_valid <= 1'b0;
            cur_ptr   <= '0;
            sym_idx   <= '0;
            nxt       <= '0;
            nxt_valid <= 1'b0;
            nxt_ptr   <= '0;
            inflight  <= 1'b0;
            fl_ptr    <= '0;
            rd_ptr_q  <= '0;
        end else begin
            inflight <= rd_en;
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                fl_ptr   <= rd_ptr_q;
            end

            if (accept) begin
                sym_idx <= sym_idx + IDX_W'(1);
            end

            if (retire) begin
                if (nxt_valid) begin
                    cur       <= nxt;
                    cur_ptr   <= nxt_ptr;
                    nxt_valid <= 1'b0;
                end else if (!inflight) begin
                    cur_valid <= 1'b0;
                end
            end

            // Landing word from the read issued last cycle
            if (inflight) begin
                if (land_cur) begin
                    cur       <= rd_data;
                    cur_ptr   <= fl_ptr;
                    cur_valid <= 1'b1;
                    sym_idx   <= '0;
                end else begin
                    nxt       <= rd_data;
                    nxt_ptr   <= fl_ptr;
                    nxt_valid <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_address  = rd_ptr_q;
        rd_ptr      = rd_ptr_q;
        data_valid  = cur_valid;
        data_out    = cur_valid ? cur[{sym_idx, 1'b0} +: SYM_W] : SYM_W'(0);
        sym_address = {cur_ptr, sym_idx};
        empty       = (rd_ptr_q == wr_ptr) & ~cur_valid & ~nxt_valid;
    end

endmodule
